// File: rtl/pipelined_addsub.sv
// Pipelined add/subtract unit with carry chain split into STAGES slices.
// Latency: beat accepted at edge n shows out_valid after edge n+STAGES.
// Backpressure: global stall; whole pipe holds while out_valid && !out_ready.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   in_valid/in_ready operand handshake (a, b, cin, sub)
//   out_valid/out_ready result handshake (sum, cout, ovf, zero)
module pipelined_addsub #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int S = WIDTH / STAGES;
  localparam int L = STAGES - 1;

  // Level j holds a beat with j slices already resolved. Level 0 is the
  // conditioned operand register loaded at accept; the slice j adder sits
  // between level j and level j+1 (or the output register for j = L).
  logic [STAGES-1:0]            vld_r;
  logic [STAGES-1:0][WIDTH-1:0] a_r;
  logic [STAGES-1:0][WIDTH-1:0] b_r;   // b already inverted for subtract
  logic [STAGES-1:0][WIDTH-1:0] s_r;   // lower finished sum bits
  logic [STAGES-1:0]            c_r;   // carry into the next slice

  logic [STAGES-1:0][WIDTH-1:0] s_n;
  logic [STAGES-1:0]            c_n;
  logic                         advance;
  logic                         ovf_n;

  assign advance  = ~out_valid | out_ready;
  assign in_ready = advance;

  always_comb begin
    logic [S:0] t;
    s_n = s_r;
    c_n = '0;
    t   = '0;
    for (int j = 0; j < STAGES; j++) begin
      t = {1'b0, a_r[j][j*S +: S]} + {1'b0, b_r[j][j*S +: S]} + {{S{1'b0}}, c_r[j]};
      s_n[j][j*S +: S] = t[S-1:0];
      c_n[j]           = t[S];
    end
  end

  // Signed overflow: operands agree in sign but the result does not.
  assign ovf_n = (a_r[L][WIDTH-1] == b_r[L][WIDTH-1]) &&
                 (s_n[L][WIDTH-1] != a_r[L][WIDTH-1]);

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_r     <= '0;
      a_r       <= '0;
      b_r       <= '0;
      s_r       <= '0;
      c_r       <= '0;
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
    end else if (advance) begin
      // Operands are only sampled when in_ready is high.
      vld_r[0] <= in_valid;
      a_r[0]   <= a;
      b_r[0]   <= sub ? ~b : b;
      s_r[0]   <= '0;
      c_r[0]   <= sub | cin;
      for (int j = 1; j < STAGES; j++) begin
        vld_r[j] <= vld_r[j-1];
        a_r[j]   <= a_r[j-1];
        b_r[j]   <= b_r[j-1];
        s_r[j]   <= s_n[j-1];
        c_r[j]   <= c_n[j-1];
      end
      out_valid <= vld_r[L];
      sum       <= s_n[L];
      cout      <= c_n[L];
      ovf       <= ovf_n;
      zero      <= ~|s_n[L];
    end
  end

endmodule

// File: tb/tb_pipelined_addsub.sv
module tb_pipelined_addsub;

  localparam int W = 16;
  localparam int ST = 4;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         zero;

  int   tests = 0;
  int   fails = 0;
  bit   rnd_rdy = 1'b0;
  exp_t q[$];
  bit   hold = 1'b0;
  exp_t held;

  pipelined_addsub #(.WIDTH(W), .STAGES(ST)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
  );

  always #5 clk = ~clk;

  // Reference: plain unsigned/signed integer arithmetic.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic c, input logic s);
    exp_t e;
    int ua, ub, sa, sb, ur, sr;
    ua = int'(x);
    ub = int'(y);
    sa = int'($signed(x));
    sb = int'($signed(y));
    if (s) begin
      ur = ua - ub;
      sr = sa - sb;
      e.cout = (ua >= ub);
    end else begin
      ur = ua + ub + int'(c);
      sr = sa + sb + int'(c);
      e.cout = (ur > 65535);
    end
    e.sum  = ur[W-1:0];
    e.ovf  = (sr > 32767) || (sr < -32768);
    e.zero = (e.sum == '0);
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Scoreboard: monitor pops/compares, accepted beats are pushed.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      hold = 1'b0;
    end else begin
      if (hold) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_data", 32'({sum, cout, ovf, zero}), 32'(held));
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_beat", 32'(out_valid), 32'd0);
        end else begin
          chk("result", 32'({sum, cout, ovf, zero}), 32'(q.pop_front()));
        end
      end
      hold = out_valid && !out_ready;
      held = {sum, cout, ovf, zero};
      if (in_valid && in_ready) q.push_back(model(a, b, cin, sub));
    end
  end

  always @(posedge clk) begin
    #1;
    if (rnd_rdy) out_ready = ($urandom % 4) != 0;
  end

  // Called at posedge+1; returns at posedge+1 right after the accept edge.
  task automatic send(input logic [W-1:0] aa, input logic [W-1:0] bb,
                      input logic c, input logic s);
    int n = 0;
    in_valid = 1'b1;
    a = aa; b = bb; cin = c; sub = s;
    #1;
    while (!in_ready && n < 200) begin
      @(posedge clk); #2;
      n++;
    end
    if (n >= 200) chk("send_timeout", 32'(n), 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", 32'(q.size()), 32'd0);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_outputs", 32'({sum, cout, ovf, zero}), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;

    // 1: latency and basic add
    send(16'h1234, 16'h0FF1, 1'b1, 1'b0);
    repeat (4) begin
      @(negedge clk);
      chk("latency_early", 32'(out_valid), 32'd0);
    end
    @(negedge clk);
    chk("latency_valid", 32'(out_valid), 32'd1);
    chk("t1_sum", 32'(sum), 32'h2226);
    @(posedge clk); #1;

    // 2, 3: carry chain and subtract corners
    send(16'hFFFF, 16'h0000, 1'b1, 1'b0);
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    send(16'h0005, 16'h0007, 1'b1, 1'b1);
    send(16'h8000, 16'h0001, 1'b0, 1'b1);
    drain();

    // 4: back-to-back random stream
    for (int i = 0; i < 20; i++)
      send(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
    drain();

    // 5a: fill, stall, then drain
    out_ready = 1'b0;
    for (int i = 0; i < ST + 1; i++)
      send(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
    repeat (5) begin
      @(negedge clk);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    drain();

    // 5b: random in_valid / out_ready
    rnd_rdy = 1'b1;
    for (int i = 0; i < 500; i++) begin
      if ($urandom % 3 == 0) begin
        @(posedge clk); #1;
      end
      send(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
    end
    rnd_rdy = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    drain();

    // 6: reset mid-flight
    send(16'h1111, 16'h2222, 1'b0, 1'b0);
    send(16'h3333, 16'h4444, 1'b0, 1'b0);
    in_valid = 1'b1; a = 16'h5555; b = 16'h6666; cin = 1'b0; sub = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_outputs", 32'({sum, cout, ovf, zero}), 32'd0);
    repeat (6) begin
      @(negedge clk);
      chk("midrst_no_stale", 32'(out_valid), 32'd0);
    end
    @(posedge clk); #1;
    send(16'h0001, 16'h0001, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    @(negedge clk);
    chk("post_rst_valid", 32'(out_valid), 32'd1);
    chk("post_rst_sum", 32'(sum), 32'h0002);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
